// File: rtl/trng_sched_pkg.sv
// Shared types for the TRNG key scheduler: FSM states, fault causes and the
// delivery counter width.
package trng_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    WAIT_KEY,
    DELIVER,
    RELEASE,
    FAULT
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ALARM   = 2'b01,
    FC_TIMEOUT = 2'b10
  } fault_cause_t;

  localparam int KEY_CNT_W = 16;

endpackage

// File: rtl/trng_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping, as one-hot grant plus index.
module trng_rr_arbiter
  import trng_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int   j;
    logic found;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(i_ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && i_req[j]) begin
        found      = 1'b1;
        o_idx      = IDX_W'(j);
        o_grant[j] = 1'b1;
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/trng_key_sched.sv
// Shares one TRNG core among N_REQ key consumers: warm-up gating, round-robin
// grant, single-shot key delivery with zeroization, and a sticky fault.
module trng_key_sched
  import trng_sched_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int N_BITS_KEY     = 32,
  parameter int WARMUP_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ-1:0]      rsp_ready_i,
  output logic [N_REQ-1:0]      key_valid_o,
  output logic [N_BITS_KEY-1:0] key_o,
  output logic                  trng_enable_o,
  input  logic                  trng_key_ready_i,
  input  logic [N_BITS_KEY-1:0] trng_key_i,
  output logic                  trng_ack_read_o,
  input  logic                  trng_intr_i,
  input  logic                  clear_fault_i,
  output logic                  busy_o,
  output logic                  fault_o,
  output logic [1:0]            fault_cause_o,
  output logic [KEY_CNT_W-1:0]  keys_delivered_o
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int WARM_W = $clog2(WARMUP_CYCLES) + 1;
  localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [31:0]       TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);

  state_t                r_state, w_state_nxt;
  fault_cause_t          r_cause, w_cause_nxt;
  logic [IDX_W-1:0]      r_ptr, r_gidx, w_nxt_ptr, w_arb_ptr, w_arb_idx;
  logic [N_REQ-1:0]      r_goh, w_arb_oh;
  logic                  w_arb_any, w_req_g;
  logic [WARM_W-1:0]     r_warm;
  logic [31:0]           r_to;
  logic [N_BITS_KEY-1:0] r_key;
  logic [KEY_CNT_W-1:0]  r_keys_cnt;
  logic                  w_grant_ld, w_capture, w_delivered;

  assign w_req_g   = |(req_i & r_goh);
  assign w_nxt_ptr = (r_gidx == IDX_LAST) ? '0 : r_gidx + 1'b1;
  // RELEASE arbitrates from the slot after the one just served
  assign w_arb_ptr = (r_state == RELEASE) ? w_nxt_ptr : r_ptr;

  trng_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (req_i),
    .i_ptr   (w_arb_ptr),
    .o_grant (w_arb_oh),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_grant_ld  = 1'b0;
    w_capture   = 1'b0;
    w_delivered = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_arb_any) begin
          w_grant_ld  = 1'b1;
          w_state_nxt = WARMUP;
        end
      end
      WARMUP: begin
        if (trng_intr_i) begin
          w_state_nxt = FAULT;
          w_cause_nxt = FC_ALARM;
        end else if (!w_req_g && !w_arb_any) begin
          w_state_nxt = IDLE;
        end else begin
          w_grant_ld = !w_req_g;
          if (r_warm == '0) w_state_nxt = WAIT_KEY;
        end
      end
      WAIT_KEY: begin
        if (trng_intr_i) begin
          w_state_nxt = FAULT;
          w_cause_nxt = FC_ALARM;
        end else if (TIMEOUT_CYCLES != 0 && r_to == TO_LAST) begin
          w_state_nxt = FAULT;
          w_cause_nxt = FC_TIMEOUT;
        end else if (trng_key_ready_i) begin
          w_capture   = 1'b1;
          w_state_nxt = DELIVER;
        end else if (!w_req_g) begin
          if (w_arb_any) w_grant_ld = 1'b1;
          else           w_state_nxt = IDLE;
        end
      end
      DELIVER: begin
        if (trng_intr_i) begin
          w_state_nxt = FAULT;
          w_cause_nxt = FC_ALARM;
        end else if (|(rsp_ready_i & r_goh)) begin
          w_delivered = 1'b1;
          w_state_nxt = RELEASE;
        end else if (!w_req_g) begin
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (trng_intr_i) begin
          w_state_nxt = FAULT;
          w_cause_nxt = FC_ALARM;
        end else if (w_arb_any) begin
          w_grant_ld  = 1'b1;
          w_state_nxt = WAIT_KEY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FAULT: begin
        if (clear_fault_i && !trng_intr_i) begin
          w_state_nxt = IDLE;
          w_cause_nxt = FC_NONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cause    <= FC_NONE;
      r_ptr      <= '0;
      r_gidx     <= '0;
      r_goh      <= '0;
      r_warm     <= '0;
      r_to       <= '0;
      r_key      <= '0;
      r_keys_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
      if (w_grant_ld) begin
        r_gidx <= w_arb_idx;
        r_goh  <= w_arb_oh;
      end
      if (r_state == RELEASE) r_ptr <= w_nxt_ptr;
      if (r_state == IDLE)                         r_warm <= WARM_LOAD;
      else if (r_state == WARMUP && r_warm != '0)  r_warm <= r_warm - 1'b1;
      if (r_state == WAIT_KEY && w_state_nxt == WAIT_KEY) r_to <= r_to + 32'd1;
      else                                                r_to <= '0;
      // Key lives only while DELIVER holds it; any exit wipes it
      if (w_capture)                   r_key <= trng_key_i;
      else if (w_state_nxt != DELIVER) r_key <= '0;
      if (w_delivered && r_keys_cnt != '1) r_keys_cnt <= r_keys_cnt + 1'b1;
    end
  end

  assign key_valid_o      = (r_state == DELIVER) ? r_goh : '0;
  assign key_o            = (r_state == DELIVER) ? r_key : '0;
  assign trng_enable_o    = (r_state == WARMUP) || (r_state == WAIT_KEY) ||
                            (r_state == DELIVER) || (r_state == RELEASE);
  assign trng_ack_read_o  = (r_state == RELEASE);
  assign busy_o           = (r_state != IDLE);
  assign fault_o          = (r_state == FAULT);
  assign fault_cause_o    = r_cause;
  assign keys_delivered_o = r_keys_cnt;

endmodule
